// File: rtl/vp_control_core.sv
// 3x3 sliding-window generator over four rotating line buffers, raster-order input.
// Optional build macro VP_CONTROL_ZERO_PAD_EN: taps past the row end read 0 instead of wrapping.
module vp_control_lb #(
  parameter int DW = 12,
  parameter int RL = 640,
  parameter int AW = $clog2(RL)
) (
  input  logic                  i_clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DW-1:0]         wdata,
  input  logic [AW-1:0]         raddr,
  output logic [2:0][DW-1:0]    taps
);
  logic [DW-1:0] mem [RL];
  logic [AW:0]   s1, s2;
  logic [AW-1:0] a1, a2;
  logic          ov1, ov2;

  // contents survive reset on purpose; a restart simply overwrites them
  always_ff @(posedge i_clk)
    if (we) mem[waddr] <= wdata;

  assign s1  = {1'b0, raddr} + (AW+1)'(1);
  assign s2  = {1'b0, raddr} + (AW+1)'(2);
  assign ov1 = s1 >= (AW+1)'(RL);
  assign ov2 = s2 >= (AW+1)'(RL);
  assign a1  = ov1 ? AW'(s1 - (AW+1)'(RL)) : AW'(s1);
  assign a2  = ov2 ? AW'(s2 - (AW+1)'(RL)) : AW'(s2);

  assign taps[2] = mem[raddr];
`ifdef VP_CONTROL_ZERO_PAD_EN
  assign taps[1] = ov1 ? '0 : mem[a1];
  assign taps[0] = ov2 ? '0 : mem[a2];
`else
  assign taps[1] = mem[a1];
  assign taps[0] = mem[a2];
`endif
endmodule

module vp_control_core #(
  parameter int DW = 12,
  parameter int RL = 640
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [DW-1:0]   i_pixel_data,
  input  logic            i_pixel_data_valid,
  output logic [9*DW-1:0] o_pixel_data,
  output logic            o_pixel_valid
);
  localparam int AW = (RL > 1) ? $clog2(RL) : 1;
  localparam int CW = $clog2(4*RL + 1);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t        state;
  logic          rd;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    wr_sel, rd_sel;
  logic [CW-1:0] cnt;
  logic          wr;
  logic [3:0][2:0][DW-1:0] lb_taps;
  logic [9*DW-1:0] win;

  assign wr = i_pixel_data_valid;

  for (genvar g = 0; g < 4; g++) begin : g_lb
    vp_control_lb #(.DW(DW), .RL(RL), .AW(AW)) u_lb (
      .i_clk (i_clk),
      .we    (wr && (wr_sel == 2'(g))),
      .waddr (wr_ptr),
      .wdata (i_pixel_data),
      .raddr (rd_ptr),
      .taps  (lb_taps[g])
    );
  end

  // 2-bit selects wrap modulo 4 for free
  assign win = {lb_taps[rd_sel], lb_taps[2'(rd_sel + 2'd1)], lb_taps[2'(rd_sel + 2'd2)]};

  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      wr_ptr <= '0;
      wr_sel <= '0;
    end else if (wr) begin
      if (wr_ptr == AW'(RL-1)) begin
        wr_ptr <= '0;
        wr_sel <= wr_sel + 2'd1;
      end else begin
        wr_ptr <= wr_ptr + AW'(1);
      end
    end

  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) cnt <= '0;
    else begin
      case ({wr, rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end

  // one row per READ visit; IDLE re-evaluates the count with this row's reads already deducted
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state  <= IDLE;
      rd     <= 1'b0;
      rd_ptr <= '0;
      rd_sel <= '0;
    end else begin
      case (state)
        IDLE: if (cnt >= CW'(3*RL)) begin
          state  <= READ;
          rd     <= 1'b1;
          rd_ptr <= '0;
        end
        READ: if (rd_ptr == AW'(RL-1)) begin
          state  <= IDLE;
          rd     <= 1'b0;
          rd_ptr <= '0;
          rd_sel <= rd_sel + 2'd1;
        end else begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        default: begin
          state <= IDLE;
          rd    <= 1'b0;
        end
      endcase
    end

  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      o_pixel_data  <= '0;
      o_pixel_valid <= 1'b0;
    end else begin
      o_pixel_valid <= rd;
      if (rd) o_pixel_data <= win;
    end
endmodule

// File: tb/tb_vp_control_core.sv
// Randomized bench for vp_control_core: every window is rebuilt from the stream of written pixels.
module tb_vp_control_core;
  localparam int DW = 12;
  localparam int RL = 8;
`ifdef VP_CONTROL_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b0;
  logic [DW-1:0]   i_pixel_data = '0;
  logic            i_pixel_data_valid = 1'b0;
  logic [9*DW-1:0] o_pixel_data;
  logic            o_pixel_valid;

  vp_control_core #(.DW(DW), .RL(RL)) dut (
    .i_clk              (i_clk),
    .i_rstn             (i_rstn),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_valid      (o_pixel_valid)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] pix[$];   // every pixel written since the last reset, in stream order
  int out_cnt = 0;
  int run = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // window o belongs to stream row o/RL, column o%RL; rows r, r+1, r+2 form top/mid/bottom
  function automatic logic [9*DW-1:0] model_win(input int o);
    logic [9*DW-1:0] w;
    int n, k, idx, pos;
    logic [DW-1:0] v;
    w = '0;
    n = o / RL;
    k = o % RL;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        idx = k + j;
        pos = (n + i) * RL + (idx % RL);
        if (idx >= RL && PAD) v = '0;
        else if (pos < pix.size()) v = pix[pos];
        else v = 'x;
        w[(8 - (i*3 + j))*DW +: DW] = v;
      end
    return w;
  endfunction

  always @(negedge i_clk) begin
    if (!i_rstn) begin
      out_cnt = 0;
      run = 0;
    end else if (o_pixel_valid) begin
      chk($sformatf("win%0d", out_cnt), o_pixel_data, model_win(out_cnt));
      out_cnt++;
      run++;
    end else if (run != 0) begin
      chk("run_len", run, RL);
      run = 0;
    end
  end

  task automatic step(input bit v, input logic [DW-1:0] d);
    @(posedge i_clk);
    #1;
    i_pixel_data_valid = v;
    i_pixel_data = d;
    if (v) pix.push_back(d);
  endtask

  // producer never starts a row that would land on a buffer still being read
  task automatic push(input logic [DW-1:0] d);
    int guard = 0;
    while ((pix.size() / RL) >= (out_cnt / RL) + 4 && guard < 2000) begin
      step(1'b0, '0);
      guard++;
    end
    chk("throttle_wait", guard < 2000, 1'b1);
    step(1'b1, d);
  endtask

  task automatic wait_out(input string tag, input int target, input int budget);
    int guard = 0;
    while (out_cnt < target && guard < budget) begin
      step(1'b0, '0);
      guard++;
    end
    repeat (4) step(1'b0, '0);
    chk(tag, out_cnt, target);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #2;
    i_rstn = 1'b0;
    i_pixel_data_valid = 1'b0;
    #1;
    chk("rst_valid", o_pixel_valid, 1'b0);
    chk("rst_data", o_pixel_data, '0);
    pix.delete();
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    do_reset();

    // one pixel short of three rows: nothing may come out
    for (int i = 0; i < 3*RL - 1; i++) step(1'b1, DW'(i));
    repeat (3*RL) step(1'b0, '0);
    chk("early_out", out_cnt, 0);

    // the third row completes: count hits 3*RL, READ next edge, valid one edge later
    step(1'b1, DW'(3*RL - 1));
    step(1'b0, '0);
    @(negedge i_clk);
    chk("lat_cnt_edge", o_pixel_valid, 1'b0);
    @(negedge i_clk);
    chk("lat_rd_edge", o_pixel_valid, 1'b0);
    @(negedge i_clk);
    chk("lat_first_out", o_pixel_valid, 1'b1);
    chk("first_win", o_pixel_data,
        {DW'(0), DW'(1), DW'(2), DW'(RL), DW'(RL+1), DW'(RL+2), DW'(2*RL), DW'(2*RL+1), DW'(2*RL+2)});
    wait_out("row0_done", RL, 4*RL);

    // continuous stream of five rows: three READ visits, rotating through the buffers
    do_reset();
    for (int i = 0; i < 5*RL; i++) push(DW'($urandom));
    wait_out("stream_rows", 3*RL, 20*RL);

    // count is now 2*RL: RL-1 more must not trigger, one more must
    for (int i = 0; i < RL - 1; i++) push(DW'($urandom));
    repeat (2*RL) step(1'b0, '0);
    chk("count_hold", out_cnt, 3*RL);
    push(DW'($urandom));
    wait_out("count_resume", 4*RL, 4*RL);

    // random gaps in the producer
    for (int i = 0; i < 6*RL; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step(1'b0, '0);
      push(DW'($urandom));
    end
    wait_out("gap_rows", 10*RL, 40*RL);

    // reset in the middle of a READ row
    for (int i = 0; i < RL; i++) push(DW'($urandom));
    guard = 0;
    while (out_cnt < 10*RL + 3 && guard < 8*RL) begin
      step(1'b0, '0);
      guard++;
    end
    chk("mid_read_reached", out_cnt >= 10*RL + 3, 1'b1);
    do_reset();

    // fresh start must begin at LB0 with an empty count
    for (int i = 0; i < 3*RL - 1; i++) step(1'b1, DW'($urandom));
    repeat (3*RL) step(1'b0, '0);
    chk("post_rst_early", out_cnt, 0);
    step(1'b1, DW'($urandom));
    wait_out("post_rst_row", RL, 4*RL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vp_control_core.md
VP_CONTROL_CORE -- requirements
Module: vp_control

Interface
REQ-001 SHALL have parameter DW, default 12, pixel data width in bits.
REQ-002 SHALL have parameter RL, default 640, row length in pixels (≥3).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_pixel_data  input  DW  incoming pixel, raster order.
REQ-006 SHALL have port i_pixel_data_valid  input  1  write strobe; one pixel accepted per cycle when high.
REQ-007 SHALL have port o_pixel_data  output  9*DW  3x3 window {top row, middle row, bottom row}, each row {p[k], p[k+1], p[k+2]}, MSB first.
REQ-008 SHALL have port o_pixel_valid  output  1  o_pixel_data valid this cycle.

Function
REQ-009 SHALL contain four line buffers LB0..LB3, each RL x DW.
REQ-010 SHALL write each valid pixel to the current write buffer at its write pointer, then increment the pointer.
REQ-011 SHALL, when the write pointer wraps from RL-1 to 0, advance the write buffer select 0->1->2->3->0.
REQ-012 SHALL keep a pixel count: +1 per write, -1 per read cycle, unchanged if both occur in the same cycle.
REQ-013 SHALL implement a read FSM: state 0 = IDLE, state 1 = READ; internal read enable rd is high only in READ.
REQ-014 SHALL go IDLE->READ when pixel count ≥ 3*RL; rd stays 0 in IDLE.
REQ-015 SHALL in READ issue exactly RL read cycles (read pointer 0..RL-1), then return to IDLE and advance the read buffer select modulo 4.
REQ-016 SHALL, with read select r, use LB[r] as top row, LB[(r+1)%4] as middle, LB[(r+2)%4] as bottom.
REQ-017 SHALL have each line buffer present taps {p[k], p[k+1], p[k+2]} at read pointer k.
REQ-018 SHALL register o_pixel_data and o_pixel_valid; o_pixel_valid is high exactly one cycle after each rd cycle (latency 1), so RL consecutive valid cycles per row.
REQ-019 SHALL accept writes during READ (simultaneous write/read supported); the producer guarantees count never exceeds 4*RL; writes beyond are undefined.
REQ-020 SHALL not re-enter READ in the cycle after returning to IDLE unless count ≥ 3*RL at that time.

Reset
REQ-021 SHALL on i_rstn low asynchronously clear write/read pointers, buffer selects, pixel count, FSM (IDLE), rd, o_pixel_valid = 0, and o_pixel_data = 0.
REQ-022 SHALL not clear line buffer contents on reset; reset mid-row discards partial rows.

Configuration
REQ-023 SHALL support macro VP_CONTROL_ZERO_PAD_EN: defined -> taps with index k+1 or k+2 ≥ RL output 0.
REQ-024 SHALL without VP_CONTROL_ZERO_PAD_EN wrap such taps to index (k+j) mod RL of the same line buffer.

Verification
REQ-025 SHALL cover: reset then 3*RL-1 pixels -> rd and o_pixel_valid stay 0.
REQ-026 SHALL cover: 3*RL pixels of value = index mod 4096 (DW=12) -> first output {0,1,2, RL,RL+1,RL+2, 2RL,2RL+1,2RL+2} one cycle after rd rises.
REQ-027 SHALL cover: last two windows of a row (k=RL-2, RL-1) -> zero-padded taps with macro defined, wrapped taps (p[0], p[1]) without.
REQ-028 SHALL cover: continuous streaming of 5*RL pixels -> second READ uses LB1/LB2/LB3, third uses LB2/LB3/LB0; count returns correctly after simultaneous write/read.
REQ-029 SHALL cover: i_rstn asserted mid-READ -> o_pixel_valid drops to 0 immediately, FSM IDLE, count 0; next 3*RL pixels restart at LB0.
